// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial 8-bit subtractor: D = (A - B) mod 256, computed LSB first over
// eight SHIFT cycles with a ripple borrow flop.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   ena         - power-good, unused
//   ui_in       - operand byte, captured by load strobes
//   uio_in      - [0]=load_a, [1]=load_b, [2]=start, [7:3] unused
//   uo_out      - difference register D
//   uio_out     - [3]=busy, [4]=done, [5]=borrow, [6]=zero, others 0
//   uio_oe      - constant 8'h78
module tt_um_serial_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned W = 8;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [W-1:0]     a, a_d, b, b_d, d, d_d;
  logic             br, br_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             busy_q, done_q, borrow_q, zero_q;
  logic             busy_d, done_d, borrow_d, zero_d;

  logic load_a, load_b, start, diff;

  assign load_a = uio_in[0];
  assign load_b = uio_in[1];
  assign start  = uio_in[2];

  // ena and the spare control bits carry no function
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:3]};

  // Next-state, datapath and status-flag logic
  always_comb begin
    state_d = state;
    a_d     = a;
    b_d     = b;
    d_d     = d;
    br_d    = br;
    cnt_d   = cnt;
    diff    = a[0] ^ b[0] ^ br;

    case (state)
      IDLE, DONE: begin
        // Loads win over start; any load drops a finished result back to IDLE
        if (load_a || load_b) begin
          if (load_a) a_d = ui_in;
          if (load_b) b_d = ui_in;
          state_d = IDLE;
        end else if (start) begin
          state_d = SHIFT;
          br_d    = 1'b0;
          cnt_d   = '0;
          d_d     = '0;
        end
      end
      SHIFT: begin
        d_d   = {diff, d[W-1:1]};
        a_d   = a >> 1;
        b_d   = b >> 1;
        br_d  = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
        cnt_d = cnt + CNT_W'(1);
        if (cnt == CNT_W'(W - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Flags follow the state being entered so they are valid with it
    busy_d   = (state_d == SHIFT);
    done_d   = (state_d == DONE);
    borrow_d = (state_d == DONE) && br_d;
    zero_d   = (state_d == DONE) && (d_d == '0);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      d        <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state    <= state_d;
      a        <= a_d;
      b        <= b_d;
      d        <= d_d;
      br       <= br_d;
      cnt      <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign uo_out  = d;
  assign uio_out = {1'b0, zero_q, borrow_q, done_q, busy_q, 3'b000};
  assign uio_oe  = 8'b0111_1000;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Bench for tt_um_serial_subtractor: table of operand pairs with arithmetic
// expectations queued on start and compared on done, plus hand sequences
// for strobe collisions, ignored strobes, rerun and mid-operation reset.
module tb_tt_um_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_serial_subtractor dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       borrow;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       borrow;
    logic       zero;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, req);
    end
  endtask

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    uio_in = 8'h01; ui_in = a; tick();
    uio_in = 8'h02; ui_in = b; tick();
    uio_in = 8'h00;
  endtask

  // Start an operation; optionally pulse start|load_a during SHIFT cycle glitch_cycle
  task automatic run_op(input string name, input exp_t e, input int glitch_cycle);
    int   cycles;
    exp_t got;
    sb.push_back(e);
    uio_in = 8'h04; tick();
    uio_in = 8'h00;
    check({name, " busy_at_start"}, 8'(uio_out[3]), 8'h01);
    check({name, " flags_in_shift"}, 8'(uio_out[6:4]), 8'h00);
    cycles = 0;
    while (cycles < 20) begin
      if (cycles == glitch_cycle - 1) begin
        uio_in = 8'h05; ui_in = 8'hFF;
      end else begin
        uio_in = 8'h00;
      end
      tick();
      cycles++;
      if (uio_out[4]) break;
    end
    uio_in = 8'h00;
    check({name, " edges_to_done"}, 8'(cycles), 8'd8);
    got = sb.pop_front();
    check({name, " d"}, uo_out, got.d);
    check({name, " borrow"}, 8'(uio_out[5]), 8'(got.borrow));
    check({name, " zero"}, 8'(uio_out[6]), 8'(got.zero));
    check({name, " busy_done"}, 8'(uio_out[3]), 8'h00);
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    v.a = a;
    v.b = b;
    v.d = 8'(a - b);
    v.borrow = (a < b);
    v.zero = (v.d == 8'h00);
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.d = v.d;
    e.borrow = v.borrow;
    e.zero = v.zero;
    return e;
  endfunction

  initial begin
    exp_t e;
    vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    for (int i = 6; i < 10; i++) vecs[i] = mk(8'($urandom), 8'($urandom));

    ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00; rst_n = 1'b0;
    #1;
    check("reset uo_out", uo_out, 8'h00);
    check("reset uio_out", uio_out, 8'h00);
    check("reset uio_oe", uio_oe, 8'h78);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      load_ops(vecs[i].a, vecs[i].b);
      run_op($sformatf("vec%0d", i), to_exp(vecs[i]), 0);
    end

    // Rerun from DONE on consumed operands
    e = '{8'h00, 1'b0, 1'b1};
    run_op("rerun", e, 0);

    // Load in DONE clears done
    uio_in = 8'h01; ui_in = 8'h33; tick();
    uio_in = 8'h00;
    check("load_clears_done", 8'(uio_out[4]), 8'h00);

    // start with load_b: load wins, no operation starts
    uio_in = 8'h06; ui_in = 8'h11; tick();
    uio_in = 8'h00;
    check("start_load_busy", 8'(uio_out[4:3]), 8'h00);
    tick();
    check("start_load_idle", 8'(uio_out[4:3]), 8'h00);
    run_op("start_load_result", to_exp(mk(8'h33, 8'h11)), 0);

    // Strobes during SHIFT cycle 4 are ignored
    load_ops(8'h5A, 8'h23);
    run_op("shift_glitch", to_exp(mk(8'h5A, 8'h23)), 4);

    // Reset during SHIFT cycle 5 aborts with no residue
    load_ops(8'h5A, 8'h23);
    uio_in = 8'h04; tick();
    uio_in = 8'h00;
    repeat (4) tick();
    check("midshift busy", 8'(uio_out[3]), 8'h01);
    rst_n = 1'b0;
    #1;
    check("midreset uo_out", uo_out, 8'h00);
    check("midreset uio_out", uio_out, 8'h00);
    check("midreset uio_oe", uio_oe, 8'h78);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset idle", uio_out, 8'h00);
    load_ops(8'h80, 8'h01);
    run_op("post_reset run", to_exp(mk(8'h80, 8'h01)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
